risc16_mem_arbiter: RTL and testbench

- Single-ported memory arbiter for the 16-bit pipelined RISC core.
- Shares one synchronous instruction/data RAM between three requesters: instruction fetch (IF), MEM-stage load/store (DM) and a program loader/debug port (LD) used to preload programs and operands.
- Replaces direct hierarchical pokes into Mem.
- Issues one access per cycle, tags each in-flight read, and returns read data to the correct requester.

---
 rtl/risc16_mem_pkg.sv | 17 +
 rtl/risc16_rsp_tagpipe.sv | 31 +++
 rtl/risc16_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_risc16_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc16_mem_pkg.sv
// Shared constants for the RISC16 memory subsystem.
// - Owner tags mark which requester an in-flight read belongs to.
// - Default memory geometry: 1024 x 32-bit words.
// - HLT opcode, which the core also uses.
package risc16_mem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_DM   = 2'd2;
  localparam logic [1:0] OWN_LD   = 2'd3;

  localparam logic [5:0] OP_HLT = 6'h3F;

endpackage

// File: rtl/risc16_rsp_tagpipe.sv
// Read-response owner tracking for the memory arbiter.
// Ports:
//   clk1, rst          clock, async active-high reset
//   tag_in             owner of the read granted this cycle (OWN_NONE if none)
//   if/dm/ld_rvalid    one-cycle pulse when mem_rdata belongs to that owner
// Stage 0 lines up with the registered mem_* command. Stage 1 lines up with
// mem_rdata, so decoding stage 1 gives the rvalids.
module risc16_rsp_tagpipe
  import risc16_mem_pkg::*;
(
  input  logic       clk1,
  input  logic       rst,
  input  logic [1:0] tag_in,
  output logic       if_rvalid,
  output logic       dm_rvalid,
  output logic       ld_rvalid
);

  logic [1:0][1:0] tag_pipe;

  // A reset clears both stages, so reads already in flight are dropped.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) tag_pipe <= '0;
    else     tag_pipe <= {tag_pipe[0], tag_in};
  end

  assign if_rvalid = (tag_pipe[1] == OWN_IF);
  assign dm_rvalid = (tag_pipe[1] == OWN_DM);
  assign ld_rvalid = (tag_pipe[1] == OWN_LD);

endmodule

// File: rtl/risc16_mem_arbiter.sv
// Single-port RAM arbiter for the RISC16 core.
// - Three requesters share one synchronous RAM: fetch (IF, read only),
//   MEM-stage load/store (DM) and the loader/debug port (LD).
// - The grant is combinational. The granted command is registered onto mem_*.
// - Read data comes back two cycles after the grant, on the requester's
//   rvalid line.
// Ports:
//   clk1, rst                   clock, async active-high reset
//   halted                      masks IF requests
//   if_*/dm_*/ld_*              request / grant / rvalid per requester
//   rsp_rdata                   shared read data (copy of mem_rdata)
//   mem_en/we/addr/wdata        registered RAM command
//   mem_rdata                   RAM output, valid the cycle after mem_en
//   locked                      loader holds exclusive ownership
module risc16_mem_arbiter
  import risc16_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              halted,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  input  logic              ld_req,
  input  logic              ld_lock,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              locked
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic          if_act;
  logic          boost;
  logic [CW-1:0] wait_cnt;

  logic              cmd_en, cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [1:0]        cmd_tag;

  // A halted core's fetch request counts as no request.
  assign if_act = if_req && !halted;
  assign boost  = (wait_cnt == CW'(MAX_WAIT));

  // Priority: locked LD > boosted IF > LD > DM > IF.
  // Grants are also forced low during reset.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!rst) begin
      if (locked)               ld_gnt = ld_req;
      else if (boost && if_act) if_gnt = 1'b1;
      else if (ld_req)          ld_gnt = 1'b1;
      else if (dm_req)          dm_gnt = 1'b1;
      else if (if_act)          if_gnt = 1'b1;
    end
  end

  // Build the command of the granted requester. It is all zeros when idle.
  always_comb begin
    cmd_en    = if_gnt | dm_gnt | ld_gnt;
    cmd_we    = (dm_gnt & dm_we) | (ld_gnt & ld_we);
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_tag   = OWN_NONE;
    if (if_gnt) begin
      cmd_addr = if_addr;
      cmd_tag  = OWN_IF;
    end else if (dm_gnt) begin
      cmd_addr  = dm_addr;
      cmd_wdata = dm_wdata;
      cmd_tag   = dm_we ? OWN_NONE : OWN_DM;
    end else if (ld_gnt) begin
      cmd_addr  = ld_addr;
      cmd_wdata = ld_wdata;
      cmd_tag   = ld_we ? OWN_NONE : OWN_LD;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      locked    <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      mem_en    <= cmd_en;
      mem_we    <= cmd_we;
      mem_addr  <= cmd_addr;
      mem_wdata <= cmd_wdata;
      // The lock is taken on a granted locking access. It is held only while
      // ld_lock stays high.
      locked    <= (locked || ld_gnt) && ld_lock;
      // The wait count saturates at MAX_WAIT and stays there through a held
      // lock, so IF wins as soon as the lock drops.
      if (if_act && !if_gnt) begin
        if (!boost) wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  risc16_rsp_tagpipe u_tagpipe (
    .clk1      (clk1),
    .rst       (rst),
    .tag_in    (cmd_tag),
    .if_rvalid (if_rvalid),
    .dm_rvalid (dm_rvalid),
    .ld_rvalid (ld_rvalid)
  );

  assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// Directed bench for risc16_mem_arbiter, with a behavioural synchronous RAM.
module tb_risc16_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk1 = 1'b0, rst = 1'b0, halted = 1'b0;
  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic          ld_req = 1'b0, ld_lock = 1'b0, ld_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0, ld_addr = '0;
  logic [DW-1:0] dm_wdata = '0, ld_wdata = '0;
  logic          if_gnt, dm_gnt, ld_gnt, if_rvalid, dm_rvalid, ld_rvalid;
  logic          mem_en, mem_we, locked;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, rsp_rdata;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;

  int errors = 0;
  int checks = 0;

  risc16_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk1(clk1), .rst(rst), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .ld_req(ld_req), .ld_lock(ld_lock), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .locked(locked)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant and rvalid vectors are packed as {if, dm, ld}.
  task automatic gnts(input string tag, input logic [2:0] e);
    chk(tag, {29'b0, if_gnt, dm_gnt, ld_gnt}, {29'b0, e});
  endtask

  task automatic rv(input string tag, input logic [2:0] e);
    chk(tag, {29'b0, if_rvalid, dm_rvalid, ld_rvalid}, {29'b0, e});
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_en"}, {31'b0, mem_en}, 32'd0);
    chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
    chk({tag, "_addr"}, {22'b0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_locked"}, {31'b0, locked}, 32'd0);
    gnts({tag, "_gnt"}, 3'b000);
    rv({tag, "_rv"}, 3'b000);
  endtask

  initial begin
    logic [2:0] exp_g;
    logic       src_if;

    // Power-on reset.
    #1 rst = 1'b1;
    #2 chk_quiet("reset");
    tick(); tick();
    #1 rst = 1'b0;
    tick();

    // Loader preload under lock. IF is masked by halted, and DM is held off by the lock.
    halted = 1'b1; if_req = 1'b1; if_addr = '0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd3;
    ld_req = 1'b1; ld_lock = 1'b1; ld_we = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ld_addr  = (i == 11) ? 10'd200 : 10'(i);
      ld_wdata = (i == 11) ? 32'd7 : 32'h1000 + 32'(i);
      #1;
      gnts("pre_gnt", 3'b001);
      chk("pre_locked", {31'b0, locked}, (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) begin
        chk("pre_mem_we", {31'b0, mem_we}, 32'd1);
        chk("pre_mem_addr", {22'b0, mem_addr}, 32'(i - 1));
        chk("pre_mem_wdata", mem_wdata, 32'h1000 + 32'(i - 1));
      end
      tick();
    end
    ld_req = 1'b0;                              // idle cycle while locked
    #1 gnts("lock_idle_gnt", 3'b000);
    chk("lock_idle_locked", {31'b0, locked}, 32'd1);
    chk("pre_last_addr", {22'b0, mem_addr}, 32'd200);
    chk("pre_last_wdata", mem_wdata, 32'd7);
    tick();
    ld_lock = 1'b0;                             // lock still held this cycle
    #1 gnts("unlock_gnt", 3'b000);
    chk("unlock_locked", {31'b0, locked}, 32'd1);
    chk("idle_mem_en", {31'b0, mem_en}, 32'd0);
    tick();
    #1 gnts("post_unlock_gnt", 3'b010);
    chk("post_unlock_locked", {31'b0, locked}, 32'd0);
    tick();
    dm_req = 1'b0;
    #1 chk("dm_cmd_en", {31'b0, mem_en}, 32'd1);
    chk("dm_cmd_we", {31'b0, mem_we}, 32'd0);
    chk("dm_cmd_addr", {22'b0, mem_addr}, 32'd3);
    rv("dm_rv_early", 3'b000);
    tick();
    #1 rv("dm_rv", 3'b010);
    chk("dm_rdata", rsp_rdata, 32'h1003);
    tick();

    // Loader read-back with the lock released.
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'd200;
    #1 gnts("rb_gnt", 3'b001);
    tick();
    ld_req = 1'b0;
    #1 rv("rb_rv_t1", 3'b000);
    chk("rb_mem_addr", {22'b0, mem_addr}, 32'd200);
    tick();
    #1 rv("rb_rv_t2", 3'b001);
    chk("rb_rdata", rsp_rdata, 32'd7);
    tick();
    #1 rv("rb_rv_t3", 3'b000);
    tick();

    // Halt masking: IF requests but never wins. DM is still served.
    halted = 1'b1; if_req = 1'b1; if_addr = 10'd2;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd1;
    for (int i = 0; i < 10; i++) begin
      #1 gnts("halt_gnt", 3'b010);
      tick();
    end

    // Contention: DM for 4 cycles, then IF by boost, then repeat.
    // Responses follow the grant order.
    halted = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 10) begin if_req = 1'b0; dm_req = 1'b0; end
      #1;
      exp_g = (k >= 10) ? 3'b000 : ((k % 5 == 4) ? 3'b100 : 3'b010);
      gnts("cont_gnt", exp_g);
      src_if = (k >= 2) && ((k - 2) % 5 == 4);
      rv("cont_rv", src_if ? 3'b100 : 3'b010);
      chk("cont_rdata", rsp_rdata, src_if ? 32'h1002 : 32'h1001);
      tick();
    end

    // Store, then fetch the same address on the next cycle.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd5; dm_wdata = 32'h15495000;
    #1 gnts("st_gnt", 3'b010);
    tick();
    dm_req = 1'b0; if_req = 1'b1; if_addr = 10'd5;
    #1 gnts("fetch_gnt", 3'b100);
    chk("st_mem_we", {31'b0, mem_we}, 32'd1);
    tick();
    if_req = 1'b0;
    #1 rv("st_no_rv", 3'b000);
    chk("fetch_mem_addr", {22'b0, mem_addr}, 32'd5);
    tick();
    #1 rv("fetch_rv", 3'b100);
    chk("fetch_rdata", rsp_rdata, 32'h15495000);
    tick();

    // A held lock beats a saturated IF wait. IF then beats DM via boost.
    ld_req = 1'b1; ld_lock = 1'b1; ld_we = 1'b1; ld_addr = 10'd300; ld_wdata = 32'hAA;
    if_req = 1'b1; if_addr = 10'd5;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd1;
    for (int i = 0; i < 6; i++) begin
      #1 gnts("lockboost_gnt", 3'b001);
      tick();
    end
    ld_req = 1'b0; ld_lock = 1'b0;
    #1 gnts("lockboost_drop", 3'b000);
    tick();
    #1 gnts("boost_gnt", 3'b100);
    chk("boost_locked", {31'b0, locked}, 32'd0);
    tick();
    if_req = 1'b0; dm_req = 1'b0;
    #1 gnts("boost_idle", 3'b000);
    tick();
    #1 rv("boost_rv", 3'b100);
    chk("boost_rdata", rsp_rdata, 32'h15495000);
    tick();

    // Reset the cycle after a DM read grant: the read is dropped.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd3;
    #1 gnts("rst_pre_gnt", 3'b010);
    tick();
    #1 rst = 1'b1;
    #1 chk_quiet("rst_mid");
    tick();
    #1 rv("rst_no_rv", 3'b000);
    rst = 1'b0;
    #1 gnts("rst_after_gnt", 3'b010);
    tick();
    dm_req = 1'b0;
    #1 rv("rst_after_rv0", 3'b000);
    chk("rst_after_addr", {22'b0, mem_addr}, 32'd3);
    tick();
    #1 rv("rst_after_rv", 3'b010);
    chk("rst_after_rdata", rsp_rdata, 32'h1003);
    tick();

    // Reset while locked releases the lock.
    ld_req = 1'b1; ld_lock = 1'b1; ld_we = 1'b1; ld_addr = 10'd400; ld_wdata = '0;
    #1 gnts("rl_gnt", 3'b001);
    tick();
    #1 chk("rl_locked", {31'b0, locked}, 32'd1);
    rst = 1'b1;
    #1 chk("rl_rst_locked", {31'b0, locked}, 32'd0);
    gnts("rl_rst_gnt", 3'b000);
    ld_req = 1'b0; ld_lock = 1'b0;
    tick();
    #1 rst = 1'b0;
    tick();
    #1 chk("rl_after_locked", {31'b0, locked}, 32'd0);
    gnts("rl_after_gnt", 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
